// File: rtl/card_flip_pkg.sv
// card_flip_pkg
// Shared types and constants for the 16-card / 8-pair memory game controller.
// Optional feature macro: MOVE_LIMIT_EN (adds the LOST state use; see card_flip_ctrl).
// Contents: card geometry localparams, controller state enum, and the helper
// that extracts one card's 3-bit value from the packed shuffle map.
package card_flip_pkg;

    localparam int NUM_CARDS = 16;
    localparam int VAL_W     = 3;
    localparam int IDX_W     = 4;
    localparam int MAP_W     = NUM_CARDS * VAL_W;

    typedef enum logic [2:0] {
        IDLE,
        SHUFFLE,
        WAIT_FIRST,
        WAIT_SECOND,
        COMPARE,
        SHOW,
        WON,
        LOST
    } state_t;

    // The map is declared ascending [0:47]; card i occupies bits 3i (MSB) to
    // 3i+2 (LSB), which is exactly what an ascending +: part select returns.
    function automatic logic [VAL_W-1:0] card_val(input logic [0:MAP_W-1] map,
                                                  input logic [IDX_W-1:0] idx);
        return map[int'(idx) * VAL_W +: VAL_W];
    endfunction

endpackage

// File: rtl/card_flip_ctrl_if.sv
// card_flip_ctrl_if
// Bundles the controller's game-side signals: new-game request, shuffle
// generator handshake (shuffle_start / shuffle_done / shuffle_map), player
// selection (sel_valid / sel_idx), display read port (rd_idx / rd_val) and
// game status (face_up, matched, move_count, busy, game_won).
// Optional feature macro: MOVE_LIMIT_EN adds game_lost.
// Modports: master = player/generator/display side, slave = the controller.
interface card_flip_ctrl_if;
    import card_flip_pkg::*;

    logic                 new_game;
    logic                 shuffle_start;
    logic                 shuffle_done;
    logic [0:MAP_W-1]     shuffle_map;
    logic                 sel_valid;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W-1:0]     rd_idx;
    logic [VAL_W-1:0]     rd_val;
    logic [NUM_CARDS-1:0] face_up;
    logic [NUM_CARDS-1:0] matched;
    logic [7:0]           move_count;
    logic                 busy;
    logic                 game_won;
`ifdef MOVE_LIMIT_EN
    logic                 game_lost;
`endif

    modport master (
        output new_game, shuffle_done, shuffle_map, sel_valid, sel_idx, rd_idx,
        input  shuffle_start, rd_val, face_up, matched, move_count, busy, game_won
`ifdef MOVE_LIMIT_EN
        , input game_lost
`endif
    );

    modport slave (
        input  new_game, shuffle_done, shuffle_map, sel_valid, sel_idx, rd_idx,
        output shuffle_start, rd_val, face_up, matched, move_count, busy, game_won
`ifdef MOVE_LIMIT_EN
        , output game_lost
`endif
    );

endinterface

// File: rtl/card_flip_ctrl_hold_timer.sv
// hold_timer
// Loadable down-counter that times how long a mismatched pair stays visible.
// Ports: clk, resetn (sync, active-low), load (take value this edge),
//        value (count to load), expired (count has reached zero).
// Counts down by one per cycle until zero and then rests there.
module hold_timer #(
    parameter  int SHOW_CYCLES = 50000000,
    localparam int W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/card_flip_ctrl.sv
// card_flip_ctrl
// Game-sequencing controller for the 16-card memory game. Starts the shuffle
// generator on new_game, latches the card map, takes two selections per move,
// compares them, records matches, and keeps a mismatched pair visible for
// SHOW_CYCLES cycles before hiding it again.
// Ports: clk, resetn (sync, active-low), ctrl_if (card_flip_ctrl_if.slave).
// Optional feature macro: MOVE_LIMIT_EN -- adds parameter MOVE_LIMIT, output
// game_lost and the LOST state, entered when the move limit is used up.
module card_flip_ctrl
    import card_flip_pkg::*;
#(
    parameter int SHOW_CYCLES = 50000000
`ifdef MOVE_LIMIT_EN
    , parameter int MOVE_LIMIT = 40
`endif
) (
    input  logic            clk,
    input  logic            resetn,
    card_flip_ctrl_if.slave ctrl_if
);

    localparam int TMR_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    state_t               state_q, state_d;
    logic [0:MAP_W-1]     card_map_q, card_map_d;
    logic [IDX_W-1:0]     first_idx_q, first_idx_d;
    logic [IDX_W-1:0]     second_idx_q, second_idx_d;
    logic [NUM_CARDS-1:0] face_up_q, face_up_d;
    logic [NUM_CARDS-1:0] matched_q, matched_d;
    logic [7:0]           move_count_q, move_count_d;
    logic                 shuffle_start_q, shuffle_start_d;
    logic                 timer_load;
    logic                 timer_expired;
    logic [NUM_CARDS-1:0] pair_bits;
    logic                 pair_equal;
    logic                 win_move;

    assign pair_bits  = (NUM_CARDS'(1) << first_idx_q) | (NUM_CARDS'(1) << second_idx_q);
    assign pair_equal = (card_val(card_map_q, first_idx_q) == card_val(card_map_q, second_idx_q));
    assign win_move   = pair_equal && (&(matched_q | pair_bits));

    hold_timer #(.SHOW_CYCLES(SHOW_CYCLES)) u_hold_timer (
        .clk     (clk),
        .resetn  (resetn),
        .load    (timer_load),
        .value   (TMR_W'(SHOW_CYCLES - 1)),
        .expired (timer_expired)
    );

    always_comb begin
        state_d         = state_q;
        card_map_d      = card_map_q;
        first_idx_d     = first_idx_q;
        second_idx_d    = second_idx_q;
        face_up_d       = face_up_q;
        matched_d       = matched_q;
        move_count_d    = move_count_q;
        shuffle_start_d = 1'b0;
        timer_load      = 1'b0;

        // A restart is honoured everywhere except while the generator runs.
        if (ctrl_if.new_game && state_q != SHUFFLE) begin
            state_d         = SHUFFLE;
            shuffle_start_d = 1'b1;
            face_up_d       = '0;
            matched_d       = '0;
            move_count_d    = '0;
        end else begin
            case (state_q)
                IDLE: ;
                SHUFFLE: begin
                    if (ctrl_if.shuffle_done) begin
                        card_map_d = ctrl_if.shuffle_map;
                        state_d    = WAIT_FIRST;
                    end
                end
                WAIT_FIRST: begin
                    if (ctrl_if.sel_valid && !face_up_q[ctrl_if.sel_idx]) begin
                        face_up_d[ctrl_if.sel_idx] = 1'b1;
                        first_idx_d                = ctrl_if.sel_idx;
                        state_d                    = WAIT_SECOND;
                    end
                end
                WAIT_SECOND: begin
                    // The first card is already face-up, so this also rejects it.
                    if (ctrl_if.sel_valid && !face_up_q[ctrl_if.sel_idx]) begin
                        face_up_d[ctrl_if.sel_idx] = 1'b1;
                        second_idx_d               = ctrl_if.sel_idx;
                        state_d                    = COMPARE;
                    end
                end
                COMPARE: begin
                    move_count_d = (move_count_q == 8'hFF) ? 8'hFF : move_count_q + 8'd1;
                    if (pair_equal) begin
                        matched_d = matched_q | pair_bits;
                        state_d   = win_move ? WON : WAIT_FIRST;
                    end else begin
                        timer_load = 1'b1;
                        state_d    = SHOW;
                    end
`ifdef MOVE_LIMIT_EN
                    if (!win_move && (({1'b0, move_count_q} + 9'd1) == 9'(MOVE_LIMIT))) begin
                        timer_load = 1'b0;
                        face_up_d  = '1;
                        state_d    = LOST;
                    end
`endif
                end
                SHOW: begin
                    if (timer_expired) begin
                        face_up_d[first_idx_q]  = 1'b0;
                        face_up_d[second_idx_q] = 1'b0;
                        state_d                 = WAIT_FIRST;
                    end
                end
                WON:  ;
                LOST: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= IDLE;
            card_map_q      <= '0;
            first_idx_q     <= '0;
            second_idx_q    <= '0;
            face_up_q       <= '0;
            matched_q       <= '0;
            move_count_q    <= '0;
            shuffle_start_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            card_map_q      <= card_map_d;
            first_idx_q     <= first_idx_d;
            second_idx_q    <= second_idx_d;
            face_up_q       <= face_up_d;
            matched_q       <= matched_d;
            move_count_q    <= move_count_d;
            shuffle_start_q <= shuffle_start_d;
        end
    end

    assign ctrl_if.shuffle_start = shuffle_start_q;
    assign ctrl_if.face_up       = face_up_q;
    assign ctrl_if.matched       = matched_q;
    assign ctrl_if.move_count    = move_count_q;
    assign ctrl_if.busy          = (state_q == SHUFFLE) || (state_q == COMPARE) || (state_q == SHOW);
    assign ctrl_if.game_won      = (state_q == WON);
`ifdef MOVE_LIMIT_EN
    assign ctrl_if.game_lost     = (state_q == LOST);
`endif
    assign ctrl_if.rd_val        = face_up_q[ctrl_if.rd_idx] ? card_val(card_map_q, ctrl_if.rd_idx) : '0;

endmodule

// File: tb/tb_card_flip_ctrl.sv
// tb_card_flip_ctrl
// Randomised bench for card_flip_ctrl with SHOW_CYCLES=4 (MOVE_LIMIT=2 when
// MOVE_LIMIT_EN is defined). A driver issues one cycle of stimulus at each
// falling edge, advances a game-level reference model and queues the expected
// outputs; a monitor pops and compares them just after each rising edge.
module tb_card_flip_ctrl;
    import card_flip_pkg::*;

    localparam int SHOW_N = 4;
`ifdef MOVE_LIMIT_EN
    localparam int LIMIT = 2;
`endif

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    card_flip_ctrl_if bus ();

    card_flip_ctrl #(
        .SHOW_CYCLES(SHOW_N)
`ifdef MOVE_LIMIT_EN
        , .MOVE_LIMIT(LIMIT)
`endif
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .ctrl_if (bus)
    );

    // ---------------- reference model (game phases, not RTL encoding)
    typedef enum int {M_IDLE, M_SHUF, M_PICK1, M_PICK2, M_CMP, M_SHOW, M_WON, M_LOST} mode_t;

    mode_t       m_mode;
    logic [2:0]  m_card [16];
    logic [15:0] m_fu, m_mt;
    int          m_moves, m_a, m_b, m_show_left;
    bit          m_start;

    typedef struct {
        logic [15:0] fu;
        logic [15:0] mt;
        logic [7:0]  moves;
        logic        busy;
        logic        won;
        logic        lost;
        logic        start;
        logic [2:0]  rdv;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic model_step(input bit rst_n, input bit ng, input bit sd,
                              input logic [0:47] map, input bit sv, input int si);
        m_start = 1'b0;
        if (!rst_n) begin
            m_mode = M_IDLE; m_fu = '0; m_mt = '0; m_moves = 0;
            m_a = 0; m_b = 0; m_show_left = 0;
            for (int i = 0; i < 16; i++) m_card[i] = 3'd0;
        end else if (ng && m_mode != M_SHUF) begin
            m_mode = M_SHUF; m_start = 1'b1; m_fu = '0; m_mt = '0; m_moves = 0;
        end else begin
            case (m_mode)
                M_SHUF: if (sd) begin
                    for (int i = 0; i < 16; i++) m_card[i] = {map[3*i], map[3*i+1], map[3*i+2]};
                    m_mode = M_PICK1;
                end
                M_PICK1: if (sv && !m_fu[si]) begin m_fu[si] = 1'b1; m_a = si; m_mode = M_PICK2; end
                M_PICK2: if (sv && !m_fu[si]) begin m_fu[si] = 1'b1; m_b = si; m_mode = M_CMP; end
                M_CMP: begin
                    bit won_now;
                    int prev;
                    prev = m_moves;
                    m_moves = (m_moves >= 255) ? 255 : m_moves + 1;
                    won_now = 1'b0;
                    if (m_card[m_a] == m_card[m_b]) begin
                        m_mt[m_a] = 1'b1; m_mt[m_b] = 1'b1;
                        won_now = (m_mt == 16'hFFFF);
                        m_mode = won_now ? M_WON : M_PICK1;
                    end else begin
                        m_show_left = SHOW_N;
                        m_mode = M_SHOW;
                    end
`ifdef MOVE_LIMIT_EN
                    if (!won_now && prev + 1 == LIMIT) begin m_mode = M_LOST; m_fu = 16'hFFFF; end
`endif
                end
                M_SHOW: begin
                    m_show_left--;
                    if (m_show_left == 0) begin m_fu[m_a] = 1'b0; m_fu[m_b] = 1'b0; m_mode = M_PICK1; end
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [0:47] make_map();
        int v [16];
        logic [0:47] mp;
        logic [2:0] t;
        for (int i = 0; i < 16; i++) v[i] = i / 2;
        for (int i = 15; i > 0; i--) begin
            int j, s;
            j = $urandom_range(0, i); s = v[i]; v[i] = v[j]; v[j] = s;
        end
        for (int i = 0; i < 16; i++) begin
            t = 3'(v[i]);
            mp[3*i] = t[2]; mp[3*i+1] = t[1]; mp[3*i+2] = t[0];
        end
        return mp;
    endfunction

    function automatic int partner(input int a);
        for (int j = 0; j < 16; j++) if (j != a && m_card[j] == m_card[a]) return j;
        return a;
    endfunction

    // strat 0: casual player (random, often finds the partner);
    // strat 1: always selects a hidden card, second pick always mismatches.
    task automatic run_cycle(input bit force_rst, input bit force_ng, input int strat, input bit rand_rst);
        bit rst_n, ng, sd, sv;
        int si, ri;
        logic [63:0] junk;
        logic [0:47] map;
        exp_t e;
        @(negedge clk);
        cyc++;
        rst_n = !force_rst && !(rand_rst && $urandom_range(0, 1999) == 0);
        ng = force_ng || (strat == 0 && $urandom_range(0, 249) == 0);
        if ((m_mode == M_IDLE || m_mode == M_WON || m_mode == M_LOST) && $urandom_range(0, 5) == 0) ng = 1'b1;
        junk = {$urandom, $urandom};
        map = junk[47:0];
        sd = 1'b0;
        if (m_mode == M_SHUF && $urandom_range(0, 2) == 0) begin sd = 1'b1; map = make_map(); end
        si = $urandom_range(0, 15);
        if (strat == 0) begin
            sv = ($urandom_range(0, 9) < 6);
            if (m_mode == M_PICK2 && $urandom_range(0, 9) < 6) si = partner(m_a);
        end else begin
            sv = 1'b1;
            for (int k = 0; k < 64; k++) begin
                if (m_mode == M_PICK2) begin
                    if (!m_fu[si] && m_card[si] != m_card[m_a]) break;
                end else if (!m_fu[si]) break;
                si = $urandom_range(0, 15);
            end
        end
        ri = $urandom_range(0, 15);
        resetn           = rst_n;
        bus.new_game     = ng;
        bus.shuffle_done = sd;
        bus.shuffle_map  = map;
        bus.sel_valid    = sv;
        bus.sel_idx      = 4'(si);
        bus.rd_idx       = 4'(ri);
        model_step(rst_n, ng, sd, map, sv, si);
        e.fu    = m_fu;
        e.mt    = m_mt;
        e.moves = 8'(m_moves);
        e.busy  = (m_mode == M_SHUF || m_mode == M_CMP || m_mode == M_SHOW);
        e.won   = (m_mode == M_WON);
        e.lost  = (m_mode == M_LOST);
        e.start = m_start;
        e.rdv   = m_fu[ri] ? m_card[ri] : 3'd0;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv)
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        else
            n_pass++;
    endtask

    // ---------------- monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("face_up",       32'(bus.face_up),       32'(e.fu));
                check("matched",       32'(bus.matched),       32'(e.mt));
                check("move_count",    32'(bus.move_count),    32'(e.moves));
                check("busy",          32'(bus.busy),          32'(e.busy));
                check("game_won",      32'(bus.game_won),      32'(e.won));
                check("shuffle_start", 32'(bus.shuffle_start), 32'(e.start));
                check("rd_val",        32'(bus.rd_val),        32'(e.rdv));
`ifdef MOVE_LIMIT_EN
                check("game_lost",     32'(bus.game_lost),     32'(e.lost));
`endif
            end
        end
    end

    // ---------------- stimulus
    initial begin
        int guard;
        resetn = 1'b0;
        bus.new_game = 1'b0; bus.shuffle_done = 1'b0; bus.shuffle_map = '0;
        bus.sel_valid = 1'b0; bus.sel_idx = '0; bus.rd_idx = '0;
        m_mode = M_IDLE;
        repeat (3) run_cycle(1'b1, 1'b0, 0, 1'b0);
        repeat (6000) run_cycle(1'b0, 1'b0, 0, 1'b1);
        // Long mismatch-only game drives move_count into saturation.
        run_cycle(1'b0, 1'b1, 1, 1'b0);
        repeat (2500) run_cycle(1'b0, 1'b0, 1, 1'b0);
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/card_flip_ctrl.md
Name: card_flip_ctrl

Overview:
Game-sequencing controller for the 16-card / 8-pair memory game.
- On a new-game request it triggers the shuffle generator and latches the resulting 48-bit card map.
- It accepts player card selections and compares pairs.
- It tracks face-up and matched cards, counts moves, and holds mismatched pairs visible for a fixed time before hiding them.
- It sits between the player-input/keyboard logic, the shuffle generator and the display renderer.

Parameters:
NUM_CARDS, 16, number of cards; fixed at 16 (4-bit index).
VAL_W, 3, bits per card value (8 pair values).
SHOW_CYCLES, 50000000, cycles a mismatched pair stays face-up (1 s at 50 MHz); must be >= 1.
MOVE_LIMIT, 40, maximum moves; used only when MOVE_LIMIT_EN is defined.

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
new_game  in  1  one-cycle request to start/restart a game
shuffle_start  out  1  one-cycle pulse to the shuffle generator
shuffle_done  in  1  one-cycle pulse from the generator; map valid in the same cycle
shuffle_map  in  48  [0:47]; card i value = shuffle_map[3i] (MSB) .. shuffle_map[3i+2] (LSB)
sel_valid  in  1  player selection strobe
sel_idx  in  4  selected card index 0..15
rd_idx  in  4  display read index
rd_val  out  3  value of card rd_idx; 0 unless face_up[rd_idx]
face_up  out  16  bit i = card i visible (includes matched cards)
matched  out  16  bit i = card i permanently matched
move_count  out  8  completed pair attempts, saturates at 255
busy  out  1  1 in SHUFFLE, COMPARE and SHOW
game_won  out  1  1 while in WON

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE; shuffle_start=0, face_up=0, matched=0, move_count=0, game_won=0, internal card_map=0, first_idx=0, hold timer=0.
- Reset mid-game aborts everything immediately. No pending pulse survives reset.
- IDLE:
  - new_game -> SHUFFLE.
  - sel_valid ignored.
- Entering SHUFFLE:
  - shuffle_start=1 for exactly the first cycle in SHUFFLE.
  - face_up, matched and move_count cleared on that same edge.
- SHUFFLE:
  - Wait for shuffle_done. On the shuffle_done cycle, card_map <= shuffle_map and state -> WAIT_FIRST.
  - new_game and sel_valid ignored (the generator cannot restart mid-run).
- WAIT_FIRST:
  - sel_valid with face_up[sel_idx]=0 -> face_up[sel_idx] set next edge, first_idx <= sel_idx, state -> WAIT_SECOND.
  - A selection of an already-visible card is ignored.
- WAIT_SECOND:
  - sel_valid with face_up[sel_idx]=0 (so sel_idx != first_idx) -> face_up[sel_idx] set, second_idx <= sel_idx, state -> COMPARE.
  - Re-selecting first_idx or a matched card is ignored.
- COMPARE (exactly one cycle):
  - move_count += 1, saturating at 255.
  - If the values of first_idx and second_idx are equal: set both matched bits. If this completes matched=16'hFFFF -> WON, else -> WAIT_FIRST.
  - If unequal: load the hold timer with SHOW_CYCLES-1 and -> SHOW.
- SHOW:
  - Timer decrements each cycle.
  - At 0: clear face_up[first_idx] and face_up[second_idx], -> WAIT_FIRST.
  - Net effect: the pair is visible for SHOW_CYCLES cycles after COMPARE.
  - sel_valid ignored.
- WON: game_won=1. new_game -> SHUFFLE.
- new_game in WAIT_FIRST, WAIT_SECOND, COMPARE or SHOW -> SHUFFLE (restart). It takes priority over sel_valid in the same cycle.
- rd_val is combinational: face_up[rd_idx] ? card value of rd_idx : 0.
- Registered outputs (face_up, matched, move_count, game_won, shuffle_start, busy) all change on clk edges only.

Optional Feature:
MOVE_LIMIT_EN
- Defined:
  - Adds output game_lost (1 bit, reset 0) and state LOST.
  - In COMPARE, if the move is not a winning match and move_count+1 == MOVE_LIMIT: state -> LOST instead of WAIT_FIRST/SHOW, and face_up <= 16'hFFFF (reveal all).
  - game_lost=1 while in LOST. Only new_game leaves LOST (-> SHUFFLE).
  - A winning match on the limit move goes to WON.
- Not defined: no game_lost port, no LOST state; move_count only saturates.

Decomposition:
- Package card_flip_pkg:
  - state enum (IDLE, SHUFFLE, WAIT_FIRST, WAIT_SECOND, COMPARE, SHOW, WON, LOST).
  - NUM_CARDS, VAL_W, IDX_W=4, MAP_W=48.
  - Card-value extraction function (index -> 3-bit slice).
- Sub-module hold_timer: loadable down-counter (load, value, expired); sized by $clog2(SHOW_CYCLES).

Test Plan:
- Reset, then new_game -> shuffle_start high exactly 1 cycle. Drive shuffle_done with a map where cards 0 and 5 = 3'd2 and all others paired distinctly -> state WAIT_FIRST, face_up=0, move_count=0.
- Select 0 then 5 -> face_up=16'h0021 after the second select; one cycle later matched=16'h0021, move_count=1, rd_idx=5 gives rd_val=2.
- With SHOW_CYCLES=4, select a mismatched pair 1 and 2 -> face_up bits 1 and 2 high for exactly 4 cycles after COMPARE, then 0. sel_valid during SHOW ignored.
- Select 3 then 3 again, then a matched card -> both ignored; state stays WAIT_SECOND and move_count is unchanged.
- Match all 8 pairs -> matched=16'hFFFF, game_won=1, move_count=8. new_game -> shuffle_start pulse, matched cleared.
- new_game in WAIT_SECOND -> restart (shuffle_start pulse, face_up=0). new_game during SHUFFLE ignored. With MOVE_LIMIT_EN and MOVE_LIMIT=2, two mismatches -> game_lost=1, face_up=16'hFFFF.
